parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
- Sequences one barrier gate shared by the entry and exit lanes of the parking lot.
- Contains its own prescaler that turns clk_in into a slow tick. All gate timing (raise, open window, lower) is counted in ticks.
- Arbitrates between entry and exit requests and maintains the lot occupancy count.
- Sits between the lane sensors/buttons and the barrier motor driver; occupancy feeds the display logic.

Parameters:
- CLK_DIV, 10000000, clk_in cycles per tick (>=2).
- RAISE_TICKS, 3, ticks the motor is driven up.
- OPEN_TICKS, 10, maximum ticks the gate waits open for a car to pass.
- LOWER_TICKS, 3, ticks the motor is driven down.
- CAPACITY, 16, lot spaces (>=1).
- OCC_W, 5, occupancy width; must satisfy 2^OCC_W > CAPACITY.

Ports:
- clk_in, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- entry_req, input, 1, level request from entry lane; synchronous, held by requester until busy is seen.
- exit_req, input, 1, level request from exit lane; same rules as entry_req.
- car_clear, input, 1, pass sensor; a 1-cycle or longer pulse means the car has passed.
- gate_up, output, 1, motor raise drive.
- gate_down, output, 1, motor lower drive.
- busy, output, 1, high in any state other than IDLE.
- dir_exit, output, 1, lane being served: 1 = exit, 0 = entry. Valid while busy.
- full, output, 1, occupancy == CAPACITY.
- occupancy, output, OCC_W, cars in the lot.
- tick, output, 1, one-cycle prescaler pulse (debug and display pacing).

Behaviour:
- Reset values: state IDLE, prescaler 0, tick_cnt 0, occupancy 0. All outputs are 0, including full.
- Reset is asynchronous. Asserting it mid-cycle drops gate_up and gate_down immediately. Occupancy is lost.
- Prescaler:
  - Cleared to 0 on every state change and held at 0 in IDLE.
  - Otherwise increments each cycle. When it equals CLK_DIV-1: tick=1, prescaler wraps to 0, tick_cnt increments.
  - tick_cnt is cleared on every state change.
- States and outputs:
  - IDLE: both motor outputs 0.
  - RAISE: gate_up=1.
  - OPEN: both motor outputs 0.
  - LOWER: gate_down=1.
  - gate_up and gate_down are never both 1. All outputs are registered and update the cycle after the state changes.
- IDLE to RAISE:
  - Eligible entry = entry_req && !full. Eligible exit = exit_req && occupancy != 0.
  - If both are eligible, exit wins. An ineligible request is ignored and stays pending with no error.
  - dir_exit is latched on this transition.
- RAISE to OPEN: on the tick where tick_cnt == RAISE_TICKS-1. RAISE therefore lasts exactly RAISE_TICKS*CLK_DIV cycles.
- OPEN to LOWER:
  - On the first cycle car_clear=1: commit the count change. Entry: occupancy+1. Exit: occupancy-1.
  - Or on the tick where tick_cnt == OPEN_TICKS-1 (timeout): no count change.
  - If car_clear and the timeout tick coincide, car_clear wins and the count is committed.
  - car_clear is ignored in every state except OPEN.
- LOWER to IDLE: on the tick where tick_cnt == LOWER_TICKS-1.
- Requests arriving while busy are not queued. They are evaluated again in IDLE if still held.
- A requester still asserting on return to IDLE is served again. Requesters must drop their request after busy rises.
- Occupancy saturates at 0 and at CAPACITY. This can only matter if CAPACITY is changed; eligibility rules otherwise prevent it.
- full is combinational from the occupancy register.

Optional Feature:
- Macro: GATE_FAIR_ARB_EN.
- Defined: on a simultaneous eligible entry and exit, the lane not served last wins. A last_dir register, reset to 0 (entry), makes exit win the first tie.
- Not defined: exit always wins ties, and last_dir is absent.

Test Plan (CLK_DIV=4, RAISE=2, OPEN=5, LOWER=2, CAPACITY=2):
- Reset, then hold entry_req from cycle 0 -> busy rises the cycle after entry_req is sampled; gate_up=1 for exactly 8 cycles; then OPEN.
- Entry cycle with car_clear pulsed at the 3rd OPEN cycle -> occupancy goes 0 to 1 the next cycle; gate_down=1 for 8 cycles; then IDLE with busy=0.
- Entry cycle with no car_clear -> OPEN lasts exactly 20 cycles; occupancy stays unchanged.
- Two completed entries -> full=1; a further entry_req produces no gate_up; exit_req with car_clear -> occupancy 1, full=0.
- entry_req and exit_req asserted the same cycle with occupancy=1 -> dir_exit=1 served first. With GATE_FAIR_ARB_EN and last served = exit, entry is served instead.
- rst asserted during RAISE -> gate_up=0 with no clock edge; state IDLE; occupancy 0.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// parking_gate_ctrl
// Sequences one barrier gate that the entry and exit lanes share. It
// arbitrates lane requests, times the raise/open/lower phases in prescaler
// ticks, and keeps the lot occupancy count.
//
// Optional build macro: GATE_FAIR_ARB_EN
//   defined   : when entry and exit are both eligible, the lane that was not
//               served last wins (last_dir_q resets to entry, so exit wins
//               the first tie).
//   undefined : exit always wins a tie.
// ---------------------------------------------------------------------------
module parking_gate_ctrl #(
    parameter int unsigned CLK_DIV     = 10000000, // clk_in cycles per tick, >= 2
    parameter int unsigned RAISE_TICKS = 3,
    parameter int unsigned OPEN_TICKS  = 10,
    parameter int unsigned LOWER_TICKS = 3,
    parameter int unsigned CAPACITY    = 16,
    parameter int unsigned OCC_W       = 5         // 2**OCC_W > CAPACITY
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_clear,
    output logic             gate_up,
    output logic             gate_down,
    output logic             busy,
    output logic             dir_exit,
    output logic             full,
    output logic [OCC_W-1:0] occupancy,
    output logic             tick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAISE,
        S_OPEN,
        S_LOWER
    } state_e;

    localparam int unsigned PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TMAX_RO = (RAISE_TICKS > OPEN_TICKS) ? RAISE_TICKS : OPEN_TICKS;
    localparam int unsigned TMAX    = (TMAX_RO > LOWER_TICKS) ? TMAX_RO : LOWER_TICKS;
    localparam int unsigned TW      = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0]    RAISE_LAST = TW'(RAISE_TICKS - 1);
    localparam logic [TW-1:0]    OPEN_LAST  = TW'(OPEN_TICKS - 1);
    localparam logic [TW-1:0]    LOWER_LAST = TW'(LOWER_TICKS - 1);
    localparam logic [OCC_W-1:0] CAP        = OCC_W'(CAPACITY);

    state_e             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [OCC_W-1:0]   occupancy_q, occupancy_d;
    logic               dir_exit_q, dir_exit_d;
    logic               gate_up_q, gate_down_q, busy_q;
    logic               tick_now;
    logic               entry_elig, exit_elig, serve_exit;

`ifdef GATE_FAIR_ARB_EN
    logic               last_dir_q, last_dir_d;
`endif

    // Prescaler is held at 0 in IDLE, so with CLK_DIV >= 2 no tick fires there.
    assign tick_now   = (presc_q == PRESC_LAST);
    assign entry_elig = entry_req && !full;
    assign exit_elig  = exit_req && (occupancy_q != '0);

`ifdef GATE_FAIR_ARB_EN
    // On a tie, serve exit only if entry was the lane served last.
    assign serve_exit = exit_elig && (!entry_elig || !last_dir_q);
`else
    assign serve_exit = exit_elig;
`endif

    // Next-state, timing counters, occupancy commit and lane latch.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        presc_d     = tick_now ? '0 : presc_q + PW'(1);
        tick_cnt_d  = tick_now ? tick_cnt_q + TW'(1) : tick_cnt_q;
        occupancy_d = occupancy_q;
        dir_exit_d  = dir_exit_q;
`ifdef GATE_FAIR_ARB_EN
        last_dir_d  = last_dir_q;
`endif

        case (state_q)
            S_IDLE: begin
                presc_d    = '0;
                tick_cnt_d = '0;
                if (entry_elig || exit_elig) begin
                    state_d    = S_RAISE;
                    dir_exit_d = serve_exit;
`ifdef GATE_FAIR_ARB_EN
                    last_dir_d = serve_exit;
`endif
                end
            end
            S_RAISE: begin
                if (tick_now && tick_cnt_q == RAISE_LAST) state_d = S_OPEN;
            end
            S_OPEN: begin
                // A pass beats a coinciding timeout tick: the count is committed.
                if (car_clear) begin
                    state_d = S_LOWER;
                    if (dir_exit_q) begin
                        if (occupancy_q != '0) occupancy_d = occupancy_q - OCC_W'(1);
                    end else begin
                        if (occupancy_q != CAP) occupancy_d = occupancy_q + OCC_W'(1);
                    end
                end else if (tick_now && tick_cnt_q == OPEN_LAST) begin
                    state_d = S_LOWER;
                end
            end
            S_LOWER: begin
                if (tick_now && tick_cnt_q == LOWER_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every phase starts its timing from a fresh prescaler and tick count.
        if (state_d != state_q) begin
            presc_d    = '0;
            tick_cnt_d = '0;
        end
    end

    // State, counters and registered outputs; reset drops the motor drives at once.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            tick_cnt_q  <= '0;
            occupancy_q <= '0;
            dir_exit_q  <= 1'b0;
            gate_up_q   <= 1'b0;
            gate_down_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GATE_FAIR_ARB_EN
            last_dir_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_cnt_q  <= tick_cnt_d;
            occupancy_q <= occupancy_d;
            dir_exit_q  <= dir_exit_d;
            gate_up_q   <= (state_d == S_RAISE);
            gate_down_q <= (state_d == S_LOWER);
            busy_q      <= (state_d != S_IDLE);
`ifdef GATE_FAIR_ARB_EN
            last_dir_q  <= last_dir_d;
`endif
        end
    end

    assign gate_up   = gate_up_q;
    assign gate_down = gate_down_q;
    assign busy      = busy_q;
    assign dir_exit  = dir_exit_q;
    assign occupancy = occupancy_q;
    assign full      = (occupancy_q == CAP);
    assign tick      = tick_now;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for parking_gate_ctrl with CLK_DIV=4, RAISE=2, OPEN=5, LOWER=2,
// CAPACITY=2. Each table row holds its inputs for a number of cycles and the
// expected outputs are compared after every clock edge of that span.
// ---------------------------------------------------------------------------
module tb_parking_gate_ctrl;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned CAPACITY = 2;
    localparam int unsigned OCC_W    = 2;

`ifdef GATE_FAIR_ARB_EN
    localparam logic TIE_DIR = 1'b0;  // last served was exit, so entry wins
`else
    localparam logic TIE_DIR = 1'b1;  // exit always wins
`endif

    logic             clk_in = 1'b0;
    logic             rst;
    logic             entry_req, exit_req, car_clear;
    logic             gate_up, gate_down, busy, dir_exit, full, tick;
    logic [OCC_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    parking_gate_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .RAISE_TICKS(2),
        .OPEN_TICKS (5),
        .LOWER_TICKS(2),
        .CAPACITY   (CAPACITY),
        .OCC_W      (OCC_W)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .entry_req(entry_req),
        .exit_req (exit_req),
        .car_clear(car_clear),
        .gate_up  (gate_up),
        .gate_down(gate_down),
        .busy     (busy),
        .dir_exit (dir_exit),
        .full     (full),
        .occupancy(occupancy),
        .tick     (tick)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       en;
        logic       ex;
        logic       clr;
        int         cycles;
        logic       up;
        logic       down;
        logic       busy;
        logic       dir;
        logic       full;
        logic [1:0] occ;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic ex, input logic clr, input int cycles,
                       input logic up, input logic down, input logic bsy, input logic dir,
                       input logic fl, input logic [1:0] occ);
        vec_t v;
        v.en = en; v.ex = ex; v.clr = clr; v.cycles = cycles;
        v.up = up; v.down = down; v.busy = bsy; v.dir = dir; v.full = fl; v.occ = occ;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; car_clear = 1'b0;

        //   en ex clr cyc  up dn bsy dir      full occ
        // Entry, car passes in the 3rd OPEN cycle (clear ignored in RAISE/IDLE).
        add(1, 0, 0, 1,   1, 0, 1, 0,       0, 0);
        add(0, 0, 1, 7,   1, 0, 1, 0,       0, 0);
        add(0, 0, 0, 3,   0, 0, 1, 0,       0, 0);
        add(0, 0, 1, 1,   0, 1, 1, 0,       0, 1);
        add(0, 0, 0, 7,   0, 1, 1, 0,       0, 1);
        add(0, 0, 1, 2,   0, 0, 0, 0,       0, 1);
        // Entry with no pass: OPEN times out after exactly 20 cycles.
        add(1, 0, 0, 1,   1, 0, 1, 0,       0, 1);
        add(0, 0, 0, 7,   1, 0, 1, 0,       0, 1);
        add(0, 0, 0, 20,  0, 0, 1, 0,       0, 1);
        add(0, 0, 0, 8,   0, 1, 1, 0,       0, 1);
        add(0, 0, 0, 2,   0, 0, 0, 0,       0, 1);
        // Second completed entry fills the lot.
        add(1, 0, 0, 1,   1, 0, 1, 0,       0, 1);
        add(0, 0, 0, 7,   1, 0, 1, 0,       0, 1);
        add(0, 0, 0, 1,   0, 0, 1, 0,       0, 1);
        add(0, 0, 1, 1,   0, 1, 1, 0,       1, 2);
        add(0, 0, 0, 7,   0, 1, 1, 0,       1, 2);
        add(0, 0, 0, 2,   0, 0, 0, 0,       1, 2);
        // Entry while full is ignored.
        add(1, 0, 0, 5,   0, 0, 0, 0,       1, 2);
        // Exit with a pass: occupancy back to 1, full drops.
        add(0, 1, 0, 1,   1, 0, 1, 1,       1, 2);
        add(0, 0, 0, 7,   1, 0, 1, 1,       1, 2);
        add(0, 0, 0, 1,   0, 0, 1, 1,       1, 2);
        add(0, 0, 1, 1,   0, 1, 1, 1,       0, 1);
        add(0, 0, 0, 7,   0, 1, 1, 1,       0, 1);
        add(0, 0, 0, 2,   0, 0, 0, 1,       0, 1);
        // Simultaneous eligible entry and exit, then timeout (count unchanged).
        add(1, 1, 0, 1,   1, 0, 1, TIE_DIR, 0, 1);
        add(0, 0, 0, 7,   1, 0, 1, TIE_DIR, 0, 1);
        add(0, 0, 0, 20,  0, 0, 1, TIE_DIR, 0, 1);
        add(0, 0, 0, 8,   0, 1, 1, TIE_DIR, 0, 1);
        add(0, 0, 0, 2,   0, 0, 0, TIE_DIR, 0, 1);

        // Reset state.
        repeat (2) step();
        check("rst gate_up",   gate_up,   0);
        check("rst gate_down", gate_down, 0);
        check("rst busy",      busy,      0);
        check("rst dir_exit",  dir_exit,  0);
        check("rst full",      full,      0);
        check("rst occupancy", occupancy, 0);
        check("rst tick",      tick,      0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                entry_req = vecs[i].en;
                exit_req  = vecs[i].ex;
                car_clear = vecs[i].clr;
                step();
                check($sformatf("v%0d.%0d gate_up",   i, c), gate_up,   vecs[i].up);
                check($sformatf("v%0d.%0d gate_down", i, c), gate_down, vecs[i].down);
                check($sformatf("v%0d.%0d busy",      i, c), busy,      vecs[i].busy);
                check($sformatf("v%0d.%0d dir_exit",  i, c), dir_exit,  vecs[i].dir);
                check($sformatf("v%0d.%0d full",      i, c), full,      vecs[i].full);
                check($sformatf("v%0d.%0d occupancy", i, c), occupancy, vecs[i].occ);
            end
        end
        entry_req = 1'b0; exit_req = 1'b0; car_clear = 1'b0;

        // Prescaler pulse in RAISE, then asynchronous reset mid-RAISE.
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        check("raise gate_up", gate_up, 1);
        check("raise tick0",   tick,    0);
        step(); check("raise tick1", tick, 0);
        step(); check("raise tick2", tick, 0);
        step(); check("raise tick3", tick, 1);
        step(); check("raise tick4", tick, 0);
        check("raise occupancy", occupancy, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst gate_up",   gate_up,   0);
        check("async rst busy",      busy,      0);
        check("async rst occupancy", occupancy, 0);
        step();
        rst = 1'b0;
        repeat (2) step();
        check("post rst busy",    busy,    0);
        check("post rst gate_up", gate_up, 0);

        // Exit with an empty lot is not eligible.
        exit_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("empty exit busy %0d", c),    busy,    0);
            check($sformatf("empty exit gate_up %0d", c), gate_up, 0);
        end
        exit_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Motor drives must never be asserted together.
    always @(negedge clk_in) begin
        if (gate_up && gate_down) begin
            checks++;
            errors++;
            $display("FAIL motor exclusive: gate_up=%0b gate_down=%0b", gate_up, gate_down);
        end
    end

endmodule
